// File: rtl/writeback_commit_queue.sv
// Writeback commit queue: resolves decode write descriptors into final values,
// holds them in program order and retires one per cycle to the GPR write port.
package writeback_commit_queue_pkg;
    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_AW = 5;

    typedef logic [XLEN-1:0]   word_t;
    typedef logic [REG_AW-1:0] creg_addr_t;

    typedef enum logic [1:0] {
        SRC_NOP = 2'd0,
        SRC_ALU = 2'd1,
        SRC_MEM = 2'd2
    } wr_src_e;

    typedef struct packed {
        logic       valid;
        wr_src_e    src;
        word_t      value;
        creg_addr_t dst;
    } write_reg_t;
endpackage

module writeback_commit_queue
    import writeback_commit_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        in_valid,
    output logic        in_ready,
    input  write_reg_t  in_wr,
    input  word_t       in_alu,
    input  logic        mem_resp_valid,
    input  word_t       mem_resp_data,
    output logic        rf_we,
    output creg_addr_t  rf_waddr,
    output word_t       rf_wdata,
    output logic [31:0] busy_mask,
    output logic        mem_stray
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;
    logic [DEPTH-1:0] vld_q, vld_d;
    logic [DEPTH-1:0] ok_q, ok_d;
    word_t            val_q [DEPTH];
    word_t            val_d [DEPTH];
    creg_addr_t       dst_q [DEPTH];
    creg_addr_t       dst_d [DEPTH];
    logic             rf_we_q, rf_we_d;
    creg_addr_t       rf_waddr_q, rf_waddr_d;
    word_t            rf_wdata_q, rf_wdata_d;
    logic             mem_stray_q, mem_stray_d;

    logic             accept, enq, pop, fill_hit;
    logic [PW-1:0]    fill_idx, scan_idx;

    assign in_ready  = (count_q != CW'(DEPTH));
    assign rf_we     = rf_we_q;
    assign rf_waddr  = rf_waddr_q;
    assign rf_wdata  = rf_wdata_q;
    assign mem_stray = mem_stray_q;

    // Next-state: load fill, in-order retire and enqueue of resolved descriptors
    always_comb begin
        head_d      = head_q;
        tail_d      = tail_q;
        vld_d       = vld_q;
        ok_d        = ok_q;
        val_d       = val_q;
        dst_d       = dst_q;
        rf_we_d     = 1'b0;
        rf_waddr_d  = rf_waddr_q;
        rf_wdata_d  = rf_wdata_q;
        fill_hit    = 1'b0;
        fill_idx    = '0;
        scan_idx    = '0;

        accept = in_valid && in_ready;
        enq    = accept && in_wr.valid && (in_wr.dst != '0);
        pop    = vld_q[head_q] && ok_q[head_q];

        // Oldest queued entry still waiting for load data (only loads enqueue with ok=0)
        for (int unsigned i = 0; i < DEPTH; i++) begin
            scan_idx = head_q + PW'(i);
            if (!fill_hit && vld_q[scan_idx] && !ok_q[scan_idx]) begin
                fill_hit = 1'b1;
                fill_idx = scan_idx;
            end
        end

        if (mem_resp_valid && fill_hit) begin
            val_d[fill_idx] = mem_resp_data;
            ok_d[fill_idx]  = 1'b1;
        end
        mem_stray_d = mem_resp_valid && !fill_hit;

        if (pop) begin
            vld_d[head_q] = 1'b0;
            head_d        = head_q + PW'(1);
            rf_we_d       = 1'b1;
            rf_waddr_d    = dst_q[head_q];
            rf_wdata_d    = val_q[head_q];
        end

        // Tail slot is always free here since accept requires count < DEPTH
        if (enq) begin
            vld_d[tail_q] = 1'b1;
            dst_d[tail_q] = in_wr.dst;
            unique case (in_wr.src)
                SRC_ALU: begin val_d[tail_q] = in_alu;      ok_d[tail_q] = 1'b1; end
                SRC_MEM: begin val_d[tail_q] = '0;          ok_d[tail_q] = 1'b0; end
                default: begin val_d[tail_q] = in_wr.value; ok_d[tail_q] = 1'b1; end
            endcase
            tail_d = tail_q + PW'(1);
        end

        count_d = count_q + CW'(enq) - CW'(pop);
    end

    // Pending-destination mask over all queued entries
    always_comb begin
        busy_mask = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (vld_q[i]) busy_mask[dst_q[i]] = 1'b1;
        end
        busy_mask[0] = 1'b0;
    end

    // State registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            vld_q       <= '0;
            ok_q        <= '0;
            rf_we_q     <= 1'b0;
            rf_waddr_q  <= '0;
            rf_wdata_q  <= '0;
            mem_stray_q <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                val_q[i] <= '0;
                dst_q[i] <= '0;
            end
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            vld_q       <= vld_d;
            ok_q        <= ok_d;
            val_q       <= val_d;
            dst_q       <= dst_d;
            rf_we_q     <= rf_we_d;
            rf_waddr_q  <= rf_waddr_d;
            rf_wdata_q  <= rf_wdata_d;
            mem_stray_q <= mem_stray_d;
        end
    end
endmodule

// File: tb/tb_writeback_commit_queue.sv
// Bench for writeback_commit_queue: scoreboard of expected GPR writes plus
// per-scenario inline checks of latency, ready, busy mask and stray pulses.
module tb_writeback_commit_queue;
    import writeback_commit_queue_pkg::*;

    logic        clk;
    logic        resetn;
    logic        in_valid;
    logic        in_ready;
    write_reg_t  in_wr;
    word_t       in_alu;
    logic        mem_resp_valid;
    word_t       mem_resp_data;
    logic        rf_we;
    creg_addr_t  rf_waddr;
    word_t       rf_wdata;
    logic [31:0] busy_mask;
    logic        mem_stray;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } exp_t;
    exp_t exp_q[$];

    writeback_commit_queue #(.DEPTH(4)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_wr          (in_wr),
        .in_alu         (in_alu),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .rf_we          (rf_we),
        .rf_waddr       (rf_waddr),
        .rf_wdata       (rf_wdata),
        .busy_mask      (busy_mask),
        .mem_stray      (mem_stray)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: every register-file write must match the oldest expected write
    always @(negedge clk) begin
        if (resetn && rf_we) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: rf_we with waddr=%0d wdata=%h, required no write", rf_waddr, rf_wdata);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (rf_waddr !== e.addr || rf_wdata !== e.data) begin
                    errors++;
                    $display("FAIL sb_write: got waddr=%0d wdata=%h, required waddr=%0d wdata=%h",
                             rf_waddr, rf_wdata, e.addr, e.data);
                end
            end
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic dv, input wr_src_e src,
                         input logic [31:0] value, input logic [4:0] dst, input logic [31:0] alu);
        in_valid       = v;
        in_wr.valid    = dv;
        in_wr.src      = src;
        in_wr.value    = value;
        in_wr.dst      = dst;
        in_alu         = alu;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, SRC_NOP, 32'h0, 5'd0, 32'h0);
    endtask

    task automatic test_reset();
        if (rf_we !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_rf: we=%b waddr=%0d wdata=%h, required 0/0/0", rf_we, rf_waddr, rf_wdata);
        end
        checks++;
        if (mem_stray !== 1'b0 || busy_mask !== 32'h0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_flags: stray=%b busy=%h ready=%b, required 0/0/1", mem_stray, busy_mask, in_ready);
        end
        checks++;
    endtask

    task automatic test_alu_single();
        drive(1'b1, 1'b1, SRC_ALU, 32'h0, 5'd5, 32'h1234);
        exp_q.push_back('{5'd5, 32'h1234});
        step(); idle();
        checks++;
        if (busy_mask !== 32'h20 || rf_we !== 1'b0) begin
            errors++;
            $display("FAIL alu_busy: busy=%h we=%b, required 00000020/0", busy_mask, rf_we);
        end
        step();
        checks++;
        if (rf_we !== 1'b1 || busy_mask !== 32'h0) begin
            errors++;
            $display("FAIL alu_latency: we=%b busy=%h, required 1/00000000", rf_we, busy_mask);
        end
        step();
        checks++;
        if (rf_we !== 1'b0 || rf_waddr !== 5'd5 || rf_wdata !== 32'h1234) begin
            errors++;
            $display("FAIL alu_hold: we=%b waddr=%0d wdata=%h, required 0/5/00001234", rf_we, rf_waddr, rf_wdata);
        end
    endtask

    task automatic test_load_order();
        drive(1'b1, 1'b1, SRC_MEM, 32'h0, 5'd8, 32'h0);
        exp_q.push_back('{5'd8, 32'hDEADBEEF});
        step();
        drive(1'b1, 1'b1, SRC_ALU, 32'h0, 5'd9, 32'h7);
        exp_q.push_back('{5'd9, 32'h7});
        step(); idle();
        checks++;
        if (busy_mask !== 32'h300 || rf_we !== 1'b0) begin
            errors++;
            $display("FAIL load_block: busy=%h we=%b, required 00000300/0", busy_mask, rf_we);
        end
        step();
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'hDEADBEEF;
        step();
        mem_resp_valid = 1'b0;
        checks++;
        if (rf_we !== 1'b0 || mem_stray !== 1'b0) begin
            errors++;
            $display("FAIL load_fill_latency: we=%b stray=%b, required 0/0", rf_we, mem_stray);
        end
        step();
        checks++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'd8) begin
            errors++;
            $display("FAIL load_first: we=%b waddr=%0d, required 1/8", rf_we, rf_waddr);
        end
        step();
        checks++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'd9) begin
            errors++;
            $display("FAIL load_second: we=%b waddr=%0d, required 1/9", rf_we, rf_waddr);
        end
        step();
        checks++;
        if (exp_q.size() != 0 || busy_mask !== 32'h0) begin
            errors++;
            $display("FAIL load_drain: pending=%0d busy=%h, required 0/00000000", exp_q.size(), busy_mask);
        end
    endtask

    task automatic test_full();
        logic [31:0] resp [4];
        int writes;
        resp[0] = 32'hA0A0_0001; resp[1] = 32'hB0B0_0002;
        resp[2] = 32'hC0C0_0003; resp[3] = 32'hD0D0_0004;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL full_ready_%0d: ready=%b, required 1", i, in_ready);
            end
            drive(1'b1, 1'b1, SRC_MEM, 32'h0, 5'(10 + i), 32'h0);
            exp_q.push_back('{5'(10 + i), resp[i]});
            step();
        end
        // Offer one more while full; it must not be taken
        drive(1'b1, 1'b1, SRC_ALU, 32'h0, 5'd14, 32'h55);
        checks++;
        if (in_ready !== 1'b0 || busy_mask !== 32'h3C00) begin
            errors++;
            $display("FAIL full_state: ready=%b busy=%h, required 0/00003c00", in_ready, busy_mask);
        end
        step(); idle();
        writes = 0;
        for (int i = 0; i < 4; i++) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = resp[i];
            step();
            if (rf_we) writes++;
        end
        mem_resp_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (rf_we) writes++;
        end
        checks++;
        if (writes != 4 || in_ready !== 1'b1 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL full_drain: writes=%0d ready=%b pending=%0d, required 4/1/0", writes, in_ready, exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        int ready_low;
        ready_low = 0;
        for (int i = 0; i < 6; i++) begin
            logic [31:0] a;
            a = $urandom;
            if (!in_ready) ready_low++;
            if (i % 2 == 0) begin
                drive(1'b1, 1'b1, SRC_ALU, 32'h0, 5'(16 + i), a);
                exp_q.push_back('{5'(16 + i), a});
            end else begin
                drive(1'b1, 1'b1, SRC_NOP, a, 5'(16 + i), ~a);
                exp_q.push_back('{5'(16 + i), a});
            end
            step();
        end
        idle();
        step(); step(); step();
        checks++;
        if (ready_low != 0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL b2b: ready_low=%0d pending=%0d, required 0/0", ready_low, exp_q.size());
        end
    endtask

    task automatic test_dropped();
        int seen;
        drive(1'b1, 1'b0, SRC_ALU, 32'h0, 5'd3, 32'h99);
        step();
        drive(1'b1, 1'b1, SRC_ALU, 32'h0, 5'd0, 32'h77);
        step(); idle();
        seen = 0;
        for (int i = 0; i < 3; i++) begin
            if (rf_we || busy_mask != 32'h0 || !in_ready) seen++;
            step();
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL dropped: activity_cycles=%0d, required 0", seen);
        end
    endtask

    task automatic test_stray();
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'h1111;
        step();
        mem_resp_valid = 1'b0;
        checks++;
        if (mem_stray !== 1'b1 || rf_we !== 1'b0) begin
            errors++;
            $display("FAIL stray_pulse: stray=%b we=%b, required 1/0", mem_stray, rf_we);
        end
        step();
        checks++;
        if (mem_stray !== 1'b0 || rf_we !== 1'b0) begin
            errors++;
            $display("FAIL stray_end: stray=%b we=%b, required 0/0", mem_stray, rf_we);
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 1'b1, SRC_MEM, 32'h0, 5'd20, 32'h0);
        step();
        drive(1'b1, 1'b1, SRC_MEM, 32'h0, 5'd21, 32'h0);
        step(); idle();
        checks++;
        if (busy_mask !== 32'h0030_0000) begin
            errors++;
            $display("FAIL rstmid_pre: busy=%h, required 00300000", busy_mask);
        end
        resetn = 1'b0;
        #1;
        checks++;
        if (busy_mask !== 32'h0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_clear: busy=%h ready=%b, required 00000000/1", busy_mask, in_ready);
        end
        step();
        resetn = 1'b1;
        step();
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'h2222;
        step();
        mem_resp_valid = 1'b0;
        checks++;
        if (mem_stray !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_stray: stray=%b, required 1", mem_stray);
        end
        step(); step();
        checks++;
        if (rf_we !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL rstmid_nowrite: we=%b pending=%0d, required 0/0", rf_we, exp_q.size());
        end
    endtask

    initial begin
        resetn         = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
        idle();
        step();
        test_reset();
        step();
        resetn = 1'b1;
        step();
        test_alu_single();
        test_load_order();
        test_full();
        test_back_to_back();
        test_dropped();
        test_stray();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
